idli_fetch_m: RTL and testbench

IDLI_FETCH_M -- requirements
Module: idli_fetch_m

---
 rtl/idli_fetch_m.sv | 164 ++++++++++++++++
 tb/tb_idli_fetch_m.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/idli_fetch_m.sv
// idli_fetch_m: SQI instruction fetch engine. Issues a quad read (EBh), then streams nibbles.
// Rev 1.0
`default_nettype none

package idli_fetch_pkg;
   typedef logic [3:0] sqi_data_t;
endpackage

module idli_fetch_m
   import idli_fetch_pkg::*;
#(
   parameter int DUMMY_BEATS = 4
) (
   input  logic        i_fch_gck,
   input  logic        i_fch_rst_n,
   input  logic        i_fch_start,
   input  logic [15:0] i_fch_addr,
   input  logic        i_fch_stall,
   output logic        o_fch_sck,
   output logic        o_fch_cs,
   output sqi_data_t   o_fch_sio,
   output logic        o_fch_sio_oe,
   input  sqi_data_t   i_fch_sio,
   output sqi_data_t   o_fch_data,
   output logic        o_fch_data_vld,
   output logic        o_fch_busy
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      CMD   = 3'd1,
      ADDR  = 3'd2,
      DUMMY = 3'd3,
      DATA  = 3'd4
   } state_t;

   localparam logic [3:0] CMD_LAST   = 4'd1;
   localparam logic [3:0] ADDR_LAST  = 4'd5;
   localparam logic [3:0] DUMMY_LAST = 4'((DUMMY_BEATS > 0) ? (DUMMY_BEATS - 1) : 0);

   state_t      state, state_nx;
   logic        phase, phase_nx;      // 0 = phase L, 1 = phase H
   logic [3:0]  cnt, cnt_nx;
   logic        gap, gap_nx;          // cs-high cycle inserted by a redirect
   logic [23:0] addr, addr_nx;
   sqi_data_t   data, data_nx;
   logic        vld, vld_nx;

   always_ff @(posedge i_fch_gck or negedge i_fch_rst_n) begin
      if (!i_fch_rst_n) begin
         state <= IDLE;
         phase <= 1'b0;
         cnt   <= 4'd0;
         gap   <= 1'b0;
         addr  <= 24'h0;
         data  <= 4'h0;
         vld   <= 1'b0;
      end else begin
         state <= state_nx;
         phase <= phase_nx;
         cnt   <= cnt_nx;
         gap   <= gap_nx;
         addr  <= addr_nx;
         data  <= data_nx;
         vld   <= vld_nx;
      end
   end

   always_comb begin
      state_nx = state;
      phase_nx = phase;
      cnt_nx   = cnt;
      gap_nx   = gap;
      addr_nx  = addr;
      data_nx  = data;
      vld_nx   = 1'b0;

      if (i_fch_start) begin
         // Fresh start and redirect share the capture; only a redirect needs the cs-high gap.
         state_nx = CMD;
         phase_nx = 1'b0;
         cnt_nx   = 4'd0;
         gap_nx   = (state != IDLE);
         addr_nx  = {8'h00, i_fch_addr & 16'hFFFE};
      end else if (gap) begin
         gap_nx = 1'b0;
      end else begin
         case (state)
            CMD: begin
               phase_nx = ~phase;
               if (phase) begin
                  if (cnt == CMD_LAST) begin
                     state_nx = ADDR;
                     cnt_nx   = 4'd0;
                  end else begin
                     cnt_nx = cnt + 4'd1;
                  end
               end
            end
            ADDR: begin
               phase_nx = ~phase;
               if (phase) begin
                  if (cnt == ADDR_LAST) begin
                     state_nx = (DUMMY_BEATS == 0) ? DATA : DUMMY;
                     cnt_nx   = 4'd0;
                  end else begin
                     cnt_nx = cnt + 4'd1;
                  end
               end
            end
            DUMMY: begin
               phase_nx = ~phase;
               if (phase) begin
                  if (cnt == DUMMY_LAST) begin
                     state_nx = DATA;
                     cnt_nx   = 4'd0;
                  end else begin
                     cnt_nx = cnt + 4'd1;
                  end
               end
            end
            DATA: begin
               if (!phase) begin
                  phase_nx = !i_fch_stall;
               end else begin
                  phase_nx = 1'b0;
                  data_nx  = i_fch_sio;
                  vld_nx   = 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      o_fch_sio = 4'h0;
      if (!gap) begin
         if (state == CMD) begin
            o_fch_sio = cnt[0] ? 4'hB : 4'hE;
         end else if (state == ADDR) begin
            case (cnt)
               4'd0:    o_fch_sio = addr[23:20];
               4'd1:    o_fch_sio = addr[19:16];
               4'd2:    o_fch_sio = addr[15:12];
               4'd3:    o_fch_sio = addr[11:8];
               4'd4:    o_fch_sio = addr[7:4];
               4'd5:    o_fch_sio = addr[3:0];
               default: o_fch_sio = 4'h0;
            endcase
         end
      end
   end

   assign o_fch_sck      = (state != IDLE) && !gap && phase;
   assign o_fch_cs       = (state == IDLE) || gap;
   assign o_fch_sio_oe   = !gap && ((state == CMD) || (state == ADDR));
   assign o_fch_data     = data;
   assign o_fch_data_vld = vld;
   assign o_fch_busy     = (state != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_idli_fetch_m.sv
// tb_idli_fetch_m: directed self-checking bench for idli_fetch_m (DUMMY_BEATS=4 and 0).
`default_nettype none

module tb_idli_fetch_m;

   logic       gck = 1'b0;
   logic       rst_n;
   logic       start, stall;
   logic [15:0] addr;
   logic [3:0] sio_in;
   logic       sck, cs, oe, vld, busy;
   logic [3:0] sio, data;

   logic       start1, stall1;
   logic [15:0] addr1;
   logic [3:0] sio_in1;
   logic       sck1, cs1, oe1, vld1, busy1;
   logic [3:0] sio1, data1;

   int checks = 0;
   int errors = 0;

   always #5 gck = ~gck;

   idli_fetch_m #(.DUMMY_BEATS(4)) dut (
      .i_fch_gck(gck), .i_fch_rst_n(rst_n), .i_fch_start(start), .i_fch_addr(addr),
      .i_fch_stall(stall), .o_fch_sck(sck), .o_fch_cs(cs), .o_fch_sio(sio),
      .o_fch_sio_oe(oe), .i_fch_sio(sio_in), .o_fch_data(data),
      .o_fch_data_vld(vld), .o_fch_busy(busy)
   );

   idli_fetch_m #(.DUMMY_BEATS(0)) dut0 (
      .i_fch_gck(gck), .i_fch_rst_n(rst_n), .i_fch_start(start1), .i_fch_addr(addr1),
      .i_fch_stall(stall1), .o_fch_sck(sck1), .o_fch_cs(cs1), .o_fch_sio(sio1),
      .o_fch_sio_oe(oe1), .i_fch_sio(sio_in1), .o_fch_data(data1),
      .o_fch_data_vld(vld1), .o_fch_busy(busy1)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge gck);
      #1;
   endtask

   // Checks both phases of one driven beat.
   task automatic beat_out(input string tag, input logic [3:0] nib);
      chk({tag, " sckL"}, 32'(sck), 32'd0);
      chk({tag, " sioL"}, 32'(sio), 32'(nib));
      chk({tag, " oeL"}, 32'(oe), 32'd1);
      chk({tag, " cs"}, 32'(cs), 32'd0);
      tick();
      chk({tag, " sckH"}, 32'(sck), 32'd1);
      chk({tag, " sioH"}, 32'(sio), 32'(nib));
      tick();
   endtask

   logic [3:0] seq1 [8];
   logic [3:0] seq2 [8];
   logic [3:0] stream [4];

   initial begin
      seq1   = '{4'hE, 4'hB, 4'h0, 4'h0, 4'h1, 4'h2, 4'h3, 4'h4};
      seq2   = '{4'hE, 4'hB, 4'h0, 4'h0, 4'h0, 4'h1, 4'h0, 4'h0};
      stream = '{4'hA, 4'h5, 4'hF, 4'h0};
      rst_n = 1'b0; start = 1'b0; stall = 1'b0; addr = 16'h0; sio_in = 4'h0;
      start1 = 1'b0; stall1 = 1'b0; addr1 = 16'h0; sio_in1 = 4'h0;
      tick();
      tick();
      chk("rst cs", 32'(cs), 32'd1);
      chk("rst sck", 32'(sck), 32'd0);
      chk("rst oe", 32'(oe), 32'd0);
      chk("rst busy", 32'(busy), 32'd0);
      chk("rst vld", 32'(vld), 32'd0);
      chk("rst data", 32'(data), 32'd0);
      chk("rst sio", 32'(sio), 32'd0);
      rst_n = 1'b1;
      tick();
      chk("idle cs", 32'(cs), 32'd1);

      // Basic fetch: command, address, four dummy beats
      start = 1'b1; addr = 16'h1234;
      tick();
      start = 1'b0;
      chk("fetch busy", 32'(busy), 32'd1);
      for (int i = 0; i < 8; i++) beat_out($sformatf("fetch b%0d", i), seq1[i]);
      for (int i = 0; i < 4; i++) begin
         chk("dummy oeL", 32'(oe), 32'd0);
         chk("dummy sioL", 32'(sio), 32'd0);
         chk("dummy vld", 32'(vld), 32'd0);
         tick();
         chk("dummy sckH", 32'(sck), 32'd1);
         chk("dummy oeH", 32'(oe), 32'd0);
         tick();
      end

      // Data stream A,5,F,0: vld one cycle after each sampling edge, 2 gck apart
      for (int k = 0; k < 4; k++) begin
         chk("data sckL", 32'(sck), 32'd0);
         chk("data oe", 32'(oe), 32'd0);
         if (k == 0) chk("data first vld", 32'(vld), 32'd0);
         else begin
            chk("data vld", 32'(vld), 32'd1);
            chk("data nib", 32'(data), 32'(stream[k-1]));
         end
         sio_in = stream[k];
         tick();
         chk("data sckH", 32'(sck), 32'd1);
         chk("data vldH", 32'(vld), 32'd0);
         tick();
      end
      chk("data last vld", 32'(vld), 32'd1);
      chk("data last nib", 32'(data), 32'h0);

      // Stall in phase L for 5 cycles
      stall = 1'b1; sio_in = 4'h7;
      for (int i = 0; i < 5; i++) begin
         tick();
         if (i == 4) stall = 1'b0;
         chk("stall sck", 32'(sck), 32'd0);
         chk("stall vld", 32'(vld), 32'd0);
      end
      tick();
      chk("resume sckH", 32'(sck), 32'd1);
      chk("resume vldH", 32'(vld), 32'd0);
      tick();
      chk("resume vld", 32'(vld), 32'd1);
      chk("resume nib", 32'(data), 32'h7);
      sio_in = 4'h9;
      tick();
      chk("next vldH", 32'(vld), 32'd0);
      tick();
      chk("next vld", 32'(vld), 32'd1);
      chk("next nib", 32'(data), 32'h9);

      // Redirect issued in phase H: sampled nibble is discarded
      sio_in = 4'h6;
      tick();
      chk("redir pre sck", 32'(sck), 32'd1);
      start = 1'b1; addr = 16'h0100;
      tick();
      start = 1'b0;
      chk("redir cs", 32'(cs), 32'd1);
      chk("redir sck", 32'(sck), 32'd0);
      chk("redir vld", 32'(vld), 32'd0);
      chk("redir busy", 32'(busy), 32'd1);
      tick();
      for (int i = 0; i < 4; i++) beat_out($sformatf("redir b%0d", i), seq2[i]);

      // Async reset in the middle of ADDR, phase H, between clock edges
      chk("addr mid sio", 32'(sio), 32'(seq2[4]));
      tick();
      chk("addr mid sck", 32'(sck), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("arst cs", 32'(cs), 32'd1);
      chk("arst sck", 32'(sck), 32'd0);
      chk("arst oe", 32'(oe), 32'd0);
      chk("arst busy", 32'(busy), 32'd0);
      start = 1'b1;
      tick();
      chk("arst start ignored", 32'(busy), 32'd0);
      start = 1'b0;
      rst_n = 1'b1;
      tick();
      chk("post rst idle", 32'(busy), 32'd0);
      chk("post rst cs", 32'(cs), 32'd1);

      // Zero dummy beats: data follows last address beat directly
      start1 = 1'b1; addr1 = 16'h0003;
      tick();
      start1 = 1'b0;
      for (int i = 0; i < 2; i++) begin
         tick();
         tick();
      end
      for (int i = 0; i < 6; i++) begin
         chk($sformatf("zd addr%0d", i), 32'(sio1), (i == 5) ? 32'h2 : 32'h0);
         chk("zd oe", 32'(oe1), 32'd1);
         tick();
         tick();
      end
      chk("zd data oe", 32'(oe1), 32'd0);
      chk("zd data sckL", 32'(sck1), 32'd0);
      sio_in1 = 4'hC;
      tick();
      chk("zd data sckH", 32'(sck1), 32'd1);
      tick();
      chk("zd vld", 32'(vld1), 32'd1);
      chk("zd nib", 32'(data1), 32'hC);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
